grf_wb_queue: RTL
=================

// Module: grf_wb_queue
// PURPOSE
//  Write-side initiator for the GRF write port: merges W-stage writebacks with results from a
//  multi-cycle producer (MDU/CP0) into one registered GRF write per cycle (RegWrite/write_reg/wdata/PC).
//  Buffers multi-cycle results in a small FIFO and resolves write ordering.
//  Provides a forwarding lookup for writes accepted but not yet committed to the GRF.
//  Sits between the W stage and the GRF.
// PARAMETERS
//  DEPTH  4  FIFO entries for the multi-cycle source; power of 2, >=2
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  w_valid    in   1   W-stage write request; always accepted, highest priority
//  w_reg      in   5   W-stage destination register
//  w_data     in   32  W-stage write data
//  w_pc       in   32  W-stage instruction PC
//  md_valid   in   1   multi-cycle source write request
//  md_ready   out  1   queue can accept; push = md_valid & md_ready
//  md_reg     in   5   multi-cycle destination register
//  md_data    in   32  multi-cycle write data
//  md_pc      in   32  multi-cycle instruction PC
//  RegWrite   out  1   GRF write enable (registered)
//  write_reg  out  5   GRF write address (registered)
//  wdata      out  32  GRF write data (registered)
//  PC         out  32  PC of the write (registered)
//  fwd_reg    in   5   forwarding lookup register
//  fwd_hit    out  1   pending uncommitted write to fwd_reg exists
//  fwd_data   out  32  youngest pending data for fwd_reg
//  count      out  $clog2(DEPTH)+1  occupied FIFO slots (killed entries included)
// BEHAVIOUR
//  - reset low (async): RegWrite=0, write_reg=0, wdata=0, PC=0, FIFO empty, count=0; md_ready=1 after release.
//  - Entry = {valid, reg, data, pc}. md_ready = (count != DEPTH), combinational from count only.
//  - Per cycle, issue selection (result visible on outputs next edge, latency 1):
//    1) w_valid & w_reg!=0 -> issue W write; FIFO not popped.
//    2) else if count!=0 -> pop head; head valid -> issue it; head killed -> RegWrite=0 that cycle.
//    3) else RegWrite=0. w_valid & w_reg==0 behaves as no request.
//  - When RegWrite=0, write_reg/wdata/PC hold their previous values.
//  - Ordering: issuing a W write to reg r clears valid on every queued entry with reg r
//    present at that edge (those entries are older). A same-cycle push to r is younger: enqueued valid.
//  - md push with md_reg==0: handshake completes; nothing enqueued.
//  - Simultaneous push and pop: count unchanged; push into full FIFO impossible (md_ready=0).
//  - Pointers wrap modulo DEPTH.
//  - fwd (combinational): fwd_reg==0 -> hit=0. Else youngest valid queued match wins;
//    otherwise output register if RegWrite & write_reg==fwd_reg; otherwise hit=0.
//    fwd_data is 0 when hit=0.
// CONFIGURATION
//  GRF_WB_TRACE_EN defined: on every posedge where RegWrite=1 (sampled before update),
//    simulation prints "%d@%h: $%d <= %h" (time, PC, write_reg, wdata); non-synthesizable.
//  Undefined: no trace code; ports and timing identical.
// TESTING
//  - Reset low mid-stream with 3 queued entries -> RegWrite=0, count=0 immediately; no writes after release.
//  - W write $5<=0x11 (pc 0x3000) -> next cycle RegWrite=1, write_reg=5, wdata=0x11, PC=0x3000.
//  - Push 4 md entries while w_valid=1 every cycle -> count=4, md_ready=0, queued writes wait;
//    drop w_valid -> drained in FIFO order, one per cycle.
//  - Queue md $8<=0xA, then W $8<=0xB before drain -> GRF sees only 0xB; killed pop yields one RegWrite=0 cycle.
//  - Queued $9<=0x1 then $9<=0x2, fwd_reg=9 -> fwd_hit=1, fwd_data=0x2; fwd_reg=0 -> fwd_hit=0.
//  - md push $0<=0xFF -> md_ready=1 handshake, count unchanged, never written.

Source files
------------

// File: rtl/grf_wb_queue.sv
// grf_wb_queue: merges W-stage writebacks and multi-cycle (MDU/CP0)
// results into one registered GRF write per cycle, with forwarding.
//
// Ports:
//   clk, reset (async, active-low)
//   w_valid/w_reg/w_data/w_pc      W-stage write, always accepted
//   md_valid/md_ready/md_reg/...   multi-cycle source, valid/ready push
//   RegWrite/write_reg/wdata/PC    registered GRF write port
//   fwd_reg -> fwd_hit/fwd_data    lookup of accepted, uncommitted writes
//   count                          occupied FIFO slots (killed included)
//
// Parameter DEPTH: FIFO entries (power of 2, >= 2).
// Optional macro GRF_WB_TRACE_EN: simulation-only write trace.
module grf_wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     w_valid,
   input  logic [4:0]               w_reg,
   input  logic [31:0]              w_data,
   input  logic [31:0]              w_pc,
   input  logic                     md_valid,
   output logic                     md_ready,
   input  logic [4:0]               md_reg,
   input  logic [31:0]              md_data,
   input  logic [31:0]              md_pc,
   output logic                     RegWrite,
   output logic [4:0]               write_reg,
   output logic [31:0]              wdata,
   output logic [31:0]              PC,
   input  logic [4:0]               fwd_reg,
   output logic                     fwd_hit,
   output logic [31:0]              fwd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] q_valid;
   logic [4:0]       q_reg  [DEPTH];
   logic [31:0]      q_data [DEPTH];
   logic [31:0]      q_pc   [DEPTH];

   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;

   logic             w_issue;
   logic             push;
   logic             pop;
   logic [DEPTH-1:0] kill;
   logic [DEPTH-1:0] push_oh;

   assign md_ready = (count != FULL);
   assign w_issue  = w_valid & (w_reg != 5'd0);
   // Writes to $0 complete the handshake but are never stored.
   assign push     = md_valid & md_ready & (md_reg != 5'd0);
   assign pop      = ~w_issue & (count != '0);

   // A W write overtakes every queued write to the same register;
   // those queued entries are older and must never reach the GRF.
   always_comb begin
      kill    = '0;
      push_oh = '0;
      for (int i = 0; i < DEPTH; i++) begin
         kill[i] = w_issue & (q_reg[i] == w_reg);
      end
      if (push) begin
         push_oh[tail] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         q_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_reg[i]  <= '0;
            q_data[i] <= '0;
            q_pc[i]   <= '0;
         end
      end else begin
         // Same-cycle push is younger than the W write: it stays valid.
         q_valid <= (q_valid & ~kill) | push_oh;
         if (push) begin
            q_reg[tail]  <= md_reg;
            q_data[tail] <= md_data;
            q_pc[tail]   <= md_pc;
            tail         <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Output register; address/data/PC hold when nothing is written.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RegWrite  <= 1'b0;
         write_reg <= '0;
         wdata     <= '0;
         PC        <= '0;
      end else if (w_issue) begin
         RegWrite  <= 1'b1;
         write_reg <= w_reg;
         wdata     <= w_data;
         PC        <= w_pc;
      end else if (pop && q_valid[head]) begin
         RegWrite  <= 1'b1;
         write_reg <= q_reg[head];
         wdata     <= q_data[head];
         PC        <= q_pc[head];
      end else begin
         RegWrite  <= 1'b0;
      end
   end

   // Forwarding: scan oldest to youngest so the youngest queued match
   // wins; queued writes are younger than the one in the output register.
   logic [AW-1:0] idx;

   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      if (fwd_reg != 5'd0) begin
         if (RegWrite && (write_reg == fwd_reg)) begin
            fwd_hit  = 1'b1;
            fwd_data = wdata;
         end
         for (int k = 0; k < DEPTH; k++) begin
            idx = head + AW'(k);
            if (((AW+1)'(k) < count) && q_valid[idx] &&
                (q_reg[idx] == fwd_reg)) begin
               fwd_hit  = 1'b1;
               fwd_data = q_data[idx];
            end
         end
      end
   end

`ifdef GRF_WB_TRACE_EN
   always @(posedge clk) begin
      if (RegWrite) begin
         $display("%d@%h: $%d <= %h", $time, PC, write_reg, wdata);
      end
   end
`else
`endif

endmodule
